warm_up_ctrl: RTL and testbench

//  Sequences the water heater path for a wash/rinse phase: on start, drives warm_en

---
 rtl/warm_up_pkg.sv | 24 ++
 rtl/warm_up_ctrl_tick.sv | 31 +++
 rtl/warm_up_ctrl.sv | 174 +++++++++++++++++
 tb/tb_warm_up_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/warm_up_pkg.sv
// Shared encodings for the heater warm-up controller: FSM states, fault codes
// and a counter-width helper.
package warm_up_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_TIMEOUT = 2'b01,
    FC_DOOR    = 2'b10
  } fault_code_t;

  // Bits needed to hold 0..max_count inclusive; always at least 1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/warm_up_ctrl_tick.sv
// Free-running prescaler: counts 0..DIV-1 and pulses tick for the cycle in
// which the count sits at DIV-1.
module tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic srst,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/warm_up_ctrl.sv
// Heater warm-up sequencer: heats to a captured setpoint, holds there with a
// hysteresis band for a fixed number of ticks, and flags timeout/door faults.
module warm_up_ctrl
  import warm_up_pkg::*;
#(
  parameter int TEMP_W       = 8,
  parameter int TICK_DIV     = 1000,
  parameter int HEAT_TIMEOUT = 600,
  parameter int HOLD_TICKS   = 120,
  parameter int HYST         = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              door_open,
  input  logic [TEMP_W-1:0] temp_set,
  input  logic [TEMP_W-1:0] temp_meas,
  output logic              warm_en,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [2:0]        state_o
);

  localparam int HEAT_CNT_W = cnt_width(HEAT_TIMEOUT);
  localparam int HOLD_CNT_W = cnt_width(HOLD_TICKS);
  localparam logic [HEAT_CNT_W-1:0] HEAT_LAST = HEAT_CNT_W'(HEAT_TIMEOUT - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_TICKS - 1);
  localparam logic [TEMP_W-1:0]     HYST_V    = TEMP_W'(HYST);

  logic tick;

  state_t                state_reg,    state_next;
  fault_code_t           code_reg,     code_next;
  logic                  warm_en_reg,  warm_en_next;
  logic                  busy_reg,     done_reg,  fault_reg;
  logic [TEMP_W-1:0]     set_reg,      set_next;
  logic [HEAT_CNT_W-1:0] heat_cnt_reg, heat_cnt_next;
  logic [HOLD_CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [TEMP_W-1:0]     hyst_low;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .srst (rst),
    .tick (tick)
  );

  // Lower edge of the hold band, clamped at zero for small setpoints.
  always_comb begin
    hyst_low = (set_reg > HYST_V) ? set_reg - HYST_V : '0;
  end

  // Counters default to zero so that any state change clears them.
  always_comb begin
    state_next    = state_reg;
    code_next     = code_reg;
    warm_en_next  = warm_en_reg;
    set_next      = set_reg;
    heat_cnt_next = '0;
    hold_cnt_next = '0;

    if (abort) begin
      state_next   = ST_IDLE;
      code_next    = FC_NONE;
      warm_en_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          warm_en_next = 1'b0;
          if (start) begin
            if (door_open) begin
              state_next = ST_FAULT;
              code_next  = FC_DOOR;
            end else begin
              state_next   = ST_HEAT;
              code_next    = FC_NONE;
              set_next     = temp_set;
              warm_en_next = 1'b1;
            end
          end
        end

        ST_HEAT: begin
          if (door_open) begin
            state_next   = ST_FAULT;
            code_next    = FC_DOOR;
            warm_en_next = 1'b0;
          end else if (tick && heat_cnt_reg == HEAT_LAST) begin
            state_next   = ST_FAULT;
            code_next    = FC_TIMEOUT;
            warm_en_next = 1'b0;
          end else if (temp_meas >= set_reg) begin
            state_next   = ST_HOLD;
            warm_en_next = 1'b0;
          end else begin
            warm_en_next  = 1'b1;
            heat_cnt_next = heat_cnt_reg + HEAT_CNT_W'(tick);
          end
        end

        ST_HOLD: begin
          if (door_open) begin
            state_next   = ST_FAULT;
            code_next    = FC_DOOR;
            warm_en_next = 1'b0;
          end else if (tick && hold_cnt_reg == HOLD_LAST) begin
            state_next   = ST_DONE;
            warm_en_next = 1'b0;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_CNT_W'(tick);
            if (temp_meas >= set_reg) begin
              warm_en_next = 1'b0;
            end else if (temp_meas < hyst_low) begin
              warm_en_next = 1'b1;
            end
          end
        end

        ST_FAULT: begin
          warm_en_next = 1'b0;
          if (start && !door_open) begin
            state_next   = ST_HEAT;
            code_next    = FC_NONE;
            set_next     = temp_set;
            warm_en_next = 1'b1;
          end
        end

        default: begin
          state_next   = ST_IDLE;
          code_next    = FC_NONE;
          warm_en_next = 1'b0;
        end
      endcase
    end
  end

  // Status flags are decoded from the next state so they land with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      code_reg     <= FC_NONE;
      warm_en_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      fault_reg    <= 1'b0;
      set_reg      <= '0;
      heat_cnt_reg <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      code_reg     <= code_next;
      warm_en_reg  <= warm_en_next;
      busy_reg     <= (state_next == ST_HEAT) || (state_next == ST_HOLD);
      done_reg     <= (state_next == ST_DONE);
      fault_reg    <= (state_next == ST_FAULT);
      set_reg      <= set_next;
      heat_cnt_reg <= heat_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  assign warm_en    = warm_en_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign fault      = fault_reg;
  assign fault_code = code_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_warm_up_ctrl.sv
// Self-checking bench for warm_up_ctrl: directed scenarios plus random stimulus,
// all compared every cycle against a tick-counting behavioural model.
module tb_warm_up_ctrl;

  localparam int TEMP_W       = 8;
  localparam int TICK_DIV     = 4;
  localparam int HEAT_TIMEOUT = 10;
  localparam int HOLD_TICKS   = 5;
  localparam int HYST         = 2;

  localparam int S_IDLE = 0, S_HEAT = 1, S_HOLD = 2, S_DONE = 3, S_FAULT = 4;

  logic clk = 1'b0;
  logic rst, start, abort, door_open;
  logic [TEMP_W-1:0] temp_set, temp_meas;
  logic warm_en, busy, done, fault;
  logic [1:0] fault_code;
  logic [2:0] state_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: phase, elapsed ticks per phase, prescaler position.
  int m_state = S_IDLE;
  int m_set = 0;
  int m_warm = 0;
  int m_code = 0;
  int m_heat_ticks = 0;
  int m_hold_ticks = 0;
  int m_pre = 0;

  always #5 clk = ~clk;

  warm_up_ctrl #(
    .TEMP_W       (TEMP_W),
    .TICK_DIV     (TICK_DIV),
    .HEAT_TIMEOUT (HEAT_TIMEOUT),
    .HOLD_TICKS   (HOLD_TICKS),
    .HYST         (HYST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .door_open  (door_open),
    .temp_set   (temp_set),
    .temp_meas  (temp_meas),
    .warm_en    (warm_en),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .fault_code (fault_code),
    .state_o    (state_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic begin_heat();
    m_state = S_HEAT;
    m_set = int'(temp_set);
    m_warm = 1;
    m_code = 0;
    m_heat_ticks = 0;
  endtask

  // What the controller must do with the inputs presented at the coming edge.
  task automatic model_step();
    bit tick;
    int low;
    tick = (m_pre == TICK_DIV - 1);
    if (rst) begin
      m_state = S_IDLE; m_set = 0; m_warm = 0; m_code = 0;
      m_heat_ticks = 0; m_hold_ticks = 0; m_pre = 0;
      return;
    end
    m_pre = (m_pre + 1) % TICK_DIV;
    if (abort) begin
      m_state = S_IDLE; m_warm = 0; m_code = 0;
      return;
    end
    case (m_state)
      S_IDLE, S_DONE: begin
        m_warm = 0;
        if (start) begin
          if (door_open) begin m_state = S_FAULT; m_code = 2; end
          else begin_heat();
        end
      end
      S_HEAT: begin
        if (door_open) begin
          m_state = S_FAULT; m_code = 2; m_warm = 0;
        end else if (tick && m_heat_ticks + 1 >= HEAT_TIMEOUT) begin
          m_state = S_FAULT; m_code = 1; m_warm = 0;
        end else if (int'(temp_meas) >= m_set) begin
          m_state = S_HOLD; m_warm = 0; m_hold_ticks = 0;
        end else begin
          m_warm = 1;
          if (tick) m_heat_ticks++;
        end
      end
      S_HOLD: begin
        low = (m_set - HYST < 0) ? 0 : m_set - HYST;
        if (door_open) begin
          m_state = S_FAULT; m_code = 2; m_warm = 0;
        end else if (tick && m_hold_ticks + 1 >= HOLD_TICKS) begin
          m_state = S_DONE; m_warm = 0;
        end else begin
          if (tick) m_hold_ticks++;
          if (int'(temp_meas) >= m_set) m_warm = 0;
          else if (int'(temp_meas) < low) m_warm = 1;
        end
      end
      default: begin
        m_warm = 0;
        if (start && !door_open) begin_heat();
      end
    endcase
  endtask

  // One clock: advance the model, let the DUT clock, then compare all outputs.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("state_o", int'(state_o), m_state);
    chk("warm_en", int'(warm_en), m_warm);
    chk("busy", int'(busy), (m_state == S_HEAT || m_state == S_HOLD) ? 1 : 0);
    chk("done", int'(done), (m_state == S_DONE) ? 1 : 0);
    chk("fault", int'(fault), (m_state == S_FAULT) ? 1 : 0);
    chk("fault_code", int'(fault_code), m_code);
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
  endtask

  task automatic go(input int set_val);
    temp_set = TEMP_W'(set_val);
    start = 1'b1;
    cycle();
  endtask

  initial begin
    int meas;
    rst = 1'b1; start = 1'b0; abort = 1'b0; door_open = 1'b0;
    temp_set = '0; temp_meas = '0;

    do_reset();
    chk("reset_state", int'(state_o), 0);
    chk("reset_outputs", int'({warm_en, busy, done, fault, fault_code}), 0);

    // Normal run: ramp to setpoint, hold, done.
    temp_meas = 8'd20;
    go(60);
    chk("heat_state", int'(state_o), 1);
    chk("heat_warm", int'(warm_en), 1);
    for (meas = 25; meas <= 60; meas += 5) begin
      temp_meas = TEMP_W'(meas);
      cycle();
    end
    chk("hold_entry", int'(state_o), 2);
    chk("hold_entry_warm", int'(warm_en), 0);
    for (int n = 0; n < 40 && done !== 1'b1; n++) cycle();
    chk("done_reached", int'(done), 1);
    chk("done_warm", int'(warm_en), 0);

    // Hysteresis inside HOLD.
    abort = 1'b1; cycle(); abort = 1'b0;
    temp_meas = 8'd60;
    go(60);
    cycle();
    chk("hyst_hold", int'(state_o), 2);
    begin
      int seq_m [5] = '{60, 59, 58, 57, 61};
      int seq_w [5] = '{0, 0, 0, 1, 0};
      for (int i = 0; i < 5; i++) begin
        temp_meas = TEMP_W'(seq_m[i]);
        cycle();
        chk($sformatf("hyst_warm_%0d", i), int'(warm_en), seq_w[i]);
      end
    end

    // Heat-up timeout.
    abort = 1'b1; cycle(); abort = 1'b0;
    temp_meas = 8'd30;
    go(60);
    for (int n = 0; n < 60 && fault !== 1'b1; n++) cycle();
    chk("timeout_fault", int'(fault), 1);
    chk("timeout_code", int'(fault_code), 1);
    chk("timeout_warm", int'(warm_en), 0);

    // Door opens mid-HEAT; start with door open stays faulted; abort clears.
    go(60);
    chk("fault_restart", int'(state_o), 1);
    cycle();
    door_open = 1'b1;
    cycle();
    chk("door_fault", int'(state_o), 4);
    chk("door_code", int'(fault_code), 2);
    chk("door_warm", int'(warm_en), 0);
    go(60);
    chk("door_sticky", int'(state_o), 4);
    abort = 1'b1; cycle(); abort = 1'b0;
    chk("door_abort", int'(state_o), 0);
    chk("door_abort_code", int'(fault_code), 0);
    door_open = 1'b0;

    // Start while busy must not move the setpoint; abort beats door.
    temp_meas = 8'd50;
    go(60);
    go(40);
    temp_meas = 8'd50;
    cycle();
    chk("busy_start_ignored", int'(state_o), 1);
    temp_meas = 8'd60;
    cycle();
    chk("busy_hold", int'(state_o), 2);
    abort = 1'b1; door_open = 1'b1;
    cycle();
    abort = 1'b0; door_open = 1'b0;
    chk("abort_over_door", int'(state_o), 0);
    chk("abort_no_fault", int'(fault), 0);

    // Reset in HOLD while heating.
    temp_meas = 8'd60;
    go(60);
    cycle();
    temp_meas = 8'd50;
    cycle();
    chk("pre_reset_warm", int'(warm_en), 1);
    rst = 1'b1;
    cycle();
    chk("mid_reset_state", int'(state_o), 0);
    chk("mid_reset_outputs", int'({warm_en, busy, done, fault, fault_code}), 0);

    // Zero setpoint leaves HEAT on its first cycle.
    go(0);
    cycle();
    chk("zero_set_hold", int'(state_o), 2);

    // Randomised run.
    meas = 20;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if (door_open) door_open = ($urandom_range(0, 3) != 0);
      else door_open = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 9) == 0);
      if (start) begin
        temp_set = TEMP_W'($urandom_range(0, 70));
        if ($urandom_range(0, 1) == 0) meas = int'($urandom_range(0, 40));
      end
      meas = meas + int'($urandom_range(0, 6)) - 2;
      if (meas < 0) meas = 0;
      if (meas > 255) meas = 255;
      temp_meas = TEMP_W'(meas);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
